// File: rtl/sa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sa_pkg                                                        |
// | Purpose  : Shared types and helpers for the systolic matmul array:       |
// |            FSM state encoding, default accumulator width and the lane    |
// |            offset helper used to slice the packed lane buses.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package sa_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Full product width plus 8 guard bits, enough for 256 worst-case beats.
  function automatic int acc_w_default(input int dw);
    return 2 * dw + 8;
  endfunction

  // LSB position of lane `lane` in a packed bus of `w`-bit lanes (lane 0 in LSBs).
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_matmul_array_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : systolic_matmul_array_if                                      |
// | Purpose  : Job control, operand stream and result readout bundle.        |
// |            master : job issuer / operand source / result sink            |
// |            slave  : the systolic array                                   |
// |            start/k_len/signed_mode  job request (sampled in IDLE)         |
// |            in_valid/in_ready/in_a/in_b  operand beats (A column, B row)  |
// |            out_valid/out_ready/out_row/out_idx  result rows of C         |
// |            busy/done  job status                                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface systolic_matmul_array_if #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int ACC_W = sa_pkg::acc_w_default(DW),
  parameter int KW    = 16
);
  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   signed_mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [N*DW-1:0]        in_a;
  logic [N*DW-1:0]        in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [N*ACC_W-1:0]     out_row;
  logic [$clog2(N)-1:0]   out_idx;
  logic                   busy;
  logic                   done;

  modport master (
    output start, k_len, signed_mode, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_row, out_idx, busy, done
  );

  modport slave (
    input  start, k_len, signed_mode, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_row, out_idx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/sa_pe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sa_pe                                                         |
// | Purpose  : One output-stationary processing element. Registers the       |
// |            incoming A (west) and B (north) operands, forwards them       |
// |            east/south, and accumulates the product of the registered     |
// |            pair with modulo-2^ACC_W wrap.                                 |
// | Ports    : clk, rst (async, active-high)                                 |
// |            clr  synchronous clear of operands and accumulator            |
// |            en   shift/accumulate enable                                  |
// |            sgn  1 = two's-complement operands                            |
// |            a_in/b_in -> a_out/b_out  pass-through, acc  accumulator      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sa_pe #(
  parameter int DW    = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             sgn,
  input  logic [DW-1:0]    a_in,
  input  logic [DW-1:0]    b_in,
  output logic [DW-1:0]    a_out,
  output logic [DW-1:0]    b_out,
  output logic [ACC_W-1:0] acc
);
  localparam int PW = 2 * DW;

  logic [DW-1:0]        r_a;
  logic [DW-1:0]        r_b;
  logic [ACC_W-1:0]     r_acc;
  logic signed [PW-1:0] w_prod_s;
  logic [PW-1:0]        w_prod_u;
  logic [ACC_W-1:0]     w_ext_s;
  logic [ACC_W-1:0]     w_ext_u;
  logic [ACC_W-1:0]     w_ext;

  // Operands are widened before the multiply so the product is full width.
  assign w_prod_s = PW'($signed(r_a)) * PW'($signed(r_b));
  assign w_prod_u = PW'(r_a) * PW'(r_b);
  assign w_ext_s  = ACC_W'(w_prod_s);
  assign w_ext_u  = ACC_W'(w_prod_u);
  assign w_ext    = sgn ? w_ext_s : w_ext_u;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (en) begin
      r_a   <= a_in;
      r_b   <= b_in;
      r_acc <= r_acc + w_ext;
    end
  end

  assign a_out = r_a;
  assign b_out = r_b;
  assign acc   = r_acc;
endmodule
`default_nettype wire

// File: rtl/systolic_matmul_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : systolic_matmul_array                                         |
// | Purpose  : N x N output-stationary systolic engine computing C = A*B.    |
// |            Owns the job FSM (IDLE/LOAD/DRAIN/OUT), the triangular input  |
// |            skew lines and the PE grid, and reads C out row by row.       |
// | Ports    : clk, rst (async, active-high)                                 |
// |            bus  systolic_matmul_array_if.slave (job, operands, results)  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module systolic_matmul_array
  import sa_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int ACC_W = acc_w_default(DW),
  parameter int KW    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_matmul_array_if.slave  bus
);
  localparam int            IW      = $clog2(N);
  localparam logic [KW-1:0] C_DRAIN = KW'(2 * N - 1);

  state_t          r_state;
  logic [KW-1:0]   r_cnt;
  logic            r_signed;
  logic [IW-1:0]   r_idx;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic            r_done;

  logic            w_start;
  logic            w_accept;
  logic            w_shift;
  logic [N*ACC_W-1:0] w_row;

  logic [DW-1:0]    w_edge_a [N];
  logic [DW-1:0]    w_edge_b [N];
  logic [DW-1:0]    w_aout   [N][N-1];
  logic [DW-1:0]    w_bout   [N-1][N];
  logic [DW-1:0]    w_a_unused [N];
  logic [DW-1:0]    w_b_unused [N];
  logic [ACC_W-1:0] w_acc    [N][N];

  assign w_start  = bus.start && (r_state == S_IDLE);
  assign w_accept = bus.in_valid && r_in_ready;
  // The array advances every cycle of LOAD and DRAIN, bubbles included.
  assign w_shift  = (r_state == S_LOAD) || (r_state == S_DRAIN);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_signed <= bus.signed_mode;
            r_busy   <= 1'b1;
            if (bus.k_len == '0) begin
              r_state <= S_DRAIN;
              r_cnt   <= C_DRAIN;
            end else begin
              r_state    <= S_LOAD;
              r_cnt      <= bus.k_len;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (r_cnt == KW'(1)) begin
              r_state    <= S_DRAIN;
              r_cnt      <= C_DRAIN;
              r_in_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // 2N-1 zero cycles push the last beat through PE(N-1,N-1).
          if (r_cnt == KW'(1)) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
            r_idx       <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (r_idx == IW'(N - 1)) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_idx       <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------- input skew
  // Lane i is delayed i cycles; the PE's own operand register supplies the
  // remaining stage so lane 0 feeds PE(0,0) directly.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] w_inj_a;
    logic [DW-1:0] w_inj_b;

    assign w_inj_a = w_accept ? bus.in_a[lane_lo(i, DW) +: DW] : '0;
    assign w_inj_b = w_accept ? bus.in_b[lane_lo(i, DW) +: DW] : '0;

    if (i == 0) begin : g_direct
      assign w_edge_a[i] = w_inj_a;
      assign w_edge_b[i] = w_inj_b;
    end else begin : g_chain
      logic [DW-1:0] r_sa [i];
      logic [DW-1:0] r_sb [i];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < i; k++) begin
            r_sa[k] <= '0;
            r_sb[k] <= '0;
          end
        end else if (w_start) begin
          for (int k = 0; k < i; k++) begin
            r_sa[k] <= '0;
            r_sb[k] <= '0;
          end
        end else if (w_shift) begin
          r_sa[0] <= w_inj_a;
          r_sb[0] <= w_inj_b;
          for (int k = 1; k < i; k++) begin
            r_sa[k] <= r_sa[k-1];
            r_sb[k] <= r_sb[k-1];
          end
        end
      end

      assign w_edge_a[i] = r_sa[i-1];
      assign w_edge_b[i] = r_sb[i-1];
    end
  end

  // ---------------------------------------------------------- PE grid
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] w_ain;
      logic [DW-1:0] w_bin;
      logic [DW-1:0] w_ao;
      logic [DW-1:0] w_bo;

      if (j == 0) begin : g_west
        assign w_ain = w_edge_a[i];
      end else begin : g_inner_a
        assign w_ain = w_aout[i][j-1];
      end

      if (i == 0) begin : g_north
        assign w_bin = w_edge_b[j];
      end else begin : g_inner_b
        assign w_bin = w_bout[i-1][j];
      end

      // Operands leaving the east and south edges have no consumer.
      if (j == N - 1) begin : g_east
        assign w_a_unused[i] = w_ao;
      end else begin : g_fwd_a
        assign w_aout[i][j] = w_ao;
      end

      if (i == N - 1) begin : g_south
        assign w_b_unused[j] = w_bo;
      end else begin : g_fwd_b
        assign w_bout[i][j] = w_bo;
      end

      sa_pe #(
        .DW    (DW),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_start),
        .en    (w_shift),
        .sgn   (r_signed),
        .a_in  (w_ain),
        .b_in  (w_bin),
        .a_out (w_ao),
        .b_out (w_bo),
        .acc   (w_acc[i][j])
      );
    end
  end

  // ---------------------------------------------------------- readout
  always_comb begin
    w_row = '0;
    if (r_out_valid) begin
      for (int j = 0; j < N; j++) begin
        w_row[lane_lo(j, ACC_W) +: ACC_W] = w_acc[r_idx][j];
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_row   = w_row;
  assign bus.out_idx   = r_idx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: doc/systolic_matmul_array.md
# systolic_matmul_array

Parametrised output-stationary N×N systolic matrix-multiply engine computing C = A·B for A (N×K) and B (K×N), with K set per job. It is the generalised successor of the fixed 4×4 array. It adds:
- internal input skewing
- a valid/ready streaming input handshake
- runtime K and signed/unsigned mode
- a drain phase and a row-by-row result readout port with backpressure

It sits between the operand-fetch logic and the activation/writeback stage of the neural-network datapath.

## Interface
- N, 4, array dimension (rows = columns = N), 2..16
- DW, 16, operand width
- ACC_W, 2*DW+8, accumulator width per PE
- KW, 16, width of the K length field
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle job request, sampled only in IDLE
- k_len  input  KW  number of K beats for the job, latched on accepted start
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched on accepted start
- in_valid  input  1  operand beat valid
- in_ready  output  1  high only in LOAD
- in_a  input  N*DW  column k of A, lane i = A[i][k] (lane 0 in LSBs)
- in_b  input  N*DW  row k of B, lane j = B[k][j]
- out_valid  output  1  result row valid
- out_ready  input  1  result row accepted
- out_row  output  N*ACC_W  row r of C, lane j = C[r][j]
- out_idx  output  clog2(N)  row index r of current out_row
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after the last row is accepted

## Operation
- FSM states: IDLE → LOAD → DRAIN → OUT → IDLE.
- IDLE:
  - On start: clear all accumulators and skew/pipeline registers, latch k_len and signed_mode, load beat counter.
  - Go to LOAD, or go directly to DRAIN if k_len == 0.
- LOAD:
  - in_ready = 1. A beat is accepted when in_valid & in_ready.
  - Every cycle the array shifts: an accepted beat injects in_a/in_b into the skew lines; a non-accepted cycle injects zeros. A bubble therefore contributes 0·0 and never misaligns data.
  - After the k_len-th accepted beat, go to DRAIN.
- DRAIN:
  - Inject zeros for exactly 2N-1 cycles, then go to OUT.
- Skew: A lane i is delayed i cycles and B lane j is delayed j cycles before entering the edge PEs.
- Array flow: A propagates east and B propagates south, one register per PE.
- PE(i,j) computes acc ← acc + a·b every cycle. The product is full 2·DW bits, sign- or zero-extended per the latched signed_mode to ACC_W. The add wraps modulo 2^ACC_W with no saturation.
- OUT:
  - out_valid = 1, out_row = row r accumulators, out_idx = r, starting at r = 0.
  - A row is accepted when out_valid & out_ready; r then increments.
  - out_row/out_idx stay stable while out_ready is low.
  - After row N-1 is accepted: done = 1 for one cycle, go to IDLE.
- start outside IDLE is ignored. in_valid outside LOAD is ignored.
- Accumulators hold their values after OUT until the next accepted start.

## Timing
- Reset values:
  - in_ready, out_valid, busy, done = 0; out_idx = 0; out_row = 0.
  - All accumulators and pipeline registers = 0; state = IDLE.
- Reset mid-job aborts immediately to IDLE. No done pulse is produced and no partial rows are output.
- Start accepted at edge e_s: busy = 1 and in_ready = 1 from cycle e_s+1.
- A beat accepted at edge e is accumulated into PE(i,j) at edge e+1+i+j.
- Last beat accepted at edge e_L:
  - Last accumulate into PE(N-1,N-1) occurs at edge e_L+2N-1.
  - out_valid first rises in the cycle after that edge.
- With continuous in_valid and out_ready, total job length from start edge to done pulse is k_len + 2N - 1 + N + 1 cycles.
- k_len == 0: DRAIN is still 2N-1 cycles; OUT then emits N all-zero rows.

## Structure
- Package sa_pkg holds:
  - the FSM state enum (IDLE, LOAD, DRAIN, OUT)
  - the default-ACC_W helper function
  - the lane-slicing helper used on the in_a/in_b/out_row buses
- Sub-module sa_pe (one PE):
  - registered east/south pass-through
  - signed/unsigned multiply
  - wrap-around accumulator with synchronous clear
- Top level generates an N×N sa_pe grid and the triangular skew shift registers, and owns the FSM and counters.

## Test plan
- N=4, DW=16, unsigned, A = identity, B rows = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, k_len=4 -> rows out equal B exactly, out_idx 0..3, one done pulse.
- All-ones A and B, k_len=7, in_valid toggling every other cycle -> every C entry = 7; bubbles cause no corruption; out_valid rises 2N cycles after the last accepting edge.
- signed_mode=1, A all 0xFFFF, B all 0x0002, k_len=3 -> every C entry = -6 sign-extended to ACC_W. The same data with signed_mode=0 -> 3·65535·2 = 393210.
- out_ready held low 5 cycles on row 2 -> out_row/out_idx stable throughout; done only after row 3 is accepted. A start pulse during OUT is ignored.
- k_len=0 -> 2N-1 DRAIN cycles, four zero rows, done. A second job started immediately afterward clears the accumulators; no carry-over.
- rst asserted mid-LOAD after 2 beats -> all outputs 0 at once, IDLE. A fresh job then produces correct results.
- Wrap check: ACC_W overridden to 2*DW, operands 0xFFFF·0xFFFF, k_len=2 -> result = (2·0xFFFE0001) mod 2^32.
